pio_irq_servicer: RTL and testbench
===================================

Name: pio_irq_servicer

Overview:
- Avalon-MM master that services the 2-bit button PIO slave's interrupt from the initiator side.
- After reset it programs the slave's irq_mask.
- On each irq it reads edge_capture, clears it, reads the live input level, then hands one event {edges, level} to fabric logic over a valid/ready stream.
- It sits between the button PIO slave port and local control logic; no CPU is required.

Parameters:
- WIDTH, 2, number of PIO bits serviced (1..32).
- IRQ_MASK, 2'b11, value written to slave irq_mask (address 2) after reset.
- READ_LATENCY, 1, cycles from address presentation to valid readdata (slave registers readdata); legal 1..4.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- irq  in  1  level interrupt from PIO slave.
- readdata  in  32  slave read data; bits [WIDTH-1:0] used.
- address  out  2  slave word address (0 = data, 2 = irq_mask, 3 = edge_capture).
- chipselect  out  1  high for every read or write access cycle.
- write_n  out  1  low only on write cycles.
- writedata  out  32  write data; upper bits zero.
- event_valid  out  1  event available.
- event_ready  in  1  consumer accepts event.
- event_edges  out  WIDTH  captured edge_capture bits.
- event_level  out  WIDTH  input level sampled after the clear.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset, checked on the clk edge with reset=1:
  - State goes to INIT.
  - Outputs: address=0, chipselect=0, write_n=1, writedata=0, event_valid=0, event_edges=0, event_level=0.
  - busy=1 in INIT.
  - Reset mid-operation aborts the access immediately and drops any pending event. The slave is not cleared; the leftover edge_capture keeps irq asserted and is re-serviced after INIT.
- All outputs are registered, with no combinational path from input to output.
- States:
  - INIT: one write cycle (chipselect=1, write_n=0, address=2, writedata=IRQ_MASK), then IDLE.
  - IDLE: chipselect=0, write_n=1. If irq=1, go to RD_EDGE.
  - RD_EDGE: chipselect=1, write_n=1, address=3, held for READ_LATENCY+1 cycles. A latency counter starts at 0 on entry. Readdata[WIDTH-1:0] is captured into edge_reg at the end of the cycle where counter==READ_LATENCY.
    - If the captured value is 0 (spurious irq), go to IDLE with no event and no write.
    - Otherwise go to CLR_EDGE.
  - CLR_EDGE: one write cycle, address=3, writedata=zero-extended edge_reg, then RD_DATA.
  - RD_DATA: same read timing as RD_EDGE at address=0. Captures level_reg, then goes to EMIT.
  - EMIT:
    - chipselect=0.
    - event_valid=1 with event_edges=edge_reg and event_level=level_reg, both stable while valid.
    - Transfer occurs on the cycle where event_valid & event_ready.
    - Next cycle: event_valid=0, state IDLE.
- irq is ignored outside IDLE.
  - Edges arriving during CLR_EDGE..EMIT stay in slave edge_capture (if after the clear write) and re-trigger from IDLE.
  - An edge landing in the same cycle as the clear write is lost; the slave gives clear priority. This is accepted behaviour.
- The clear write deasserts slave irq by the next cycle. The path CLR_EDGE→RD_DATA→EMIT is at least 3 cycles, so IDLE never sees stale irq from a serviced capture.
- Minimum service time, irq seen to event_valid, with READ_LATENCY=1: 1 (IDLE) + 2 (RD_EDGE) + 1 (CLR) + 2 (RD_DATA) = event_valid asserted 6 cycles after the first IDLE cycle with irq=1.
- Backpressure: event_ready=0 holds EMIT indefinitely. No slave accesses occur while stalled.

Test Plan:
- Reset release with READ_LATENCY=1 → exactly one write on the first cycle: address=2, writedata=0x3. The slave model's irq_mask reads back 0x3.
- Press bit0 (slave edge_capture=01, in_port=01) → read at address 3 for 2 cycles, one write at address 3 with 0x1, read at address 0. Then event_valid=1, event_edges=01, event_level=01; irq low afterwards.
- Both bits captured (11), event_ready held 0 for 10 cycles → event_valid stays 1 with edges=11 throughout, no bus activity, and exactly one transfer when ready rises.
- Spurious irq forced high with edge_capture=00 → one read at address 3, no write, no event, back to IDLE; re-reads while irq stays high.
- Second edge on bit1 injected during EMIT → a second event follows with edges=10. No event is lost and none is duplicated.
- Reset asserted mid-RD_DATA → next cycle chipselect=0 and event_valid=0, INIT write is reissued, then the pending capture is serviced.

Source files
------------

// File: rtl/pio_irq_servicer.sv
// pio_irq_servicer: Avalon-MM master that services a button PIO interrupt and streams {edges, level} events.
// Revision 1.0
`default_nettype none

module pio_irq_servicer #(
  parameter int               WIDTH        = 2,
  parameter logic [WIDTH-1:0] IRQ_MASK     = {WIDTH{1'b1}},
  parameter int               READ_LATENCY = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             irq,
  input  logic [31:0]      readdata,
  output logic [1:0]       address,
  output logic             chipselect,
  output logic             write_n,
  output logic [31:0]      writedata,
  output logic             event_valid,
  input  logic             event_ready,
  output logic [WIDTH-1:0] event_edges,
  output logic [WIDTH-1:0] event_level,
  output logic             busy
);

  localparam logic [1:0] C_ADDR_DATA = 2'd0;
  localparam logic [1:0] C_ADDR_MASK = 2'd2;
  localparam logic [1:0] C_ADDR_EDGE = 2'd3;
  localparam logic [2:0] C_LAT       = 3'(READ_LATENCY);

  typedef enum logic [2:0] {
    S_INIT     = 3'd0,
    S_IDLE     = 3'd1,
    S_RD_EDGE  = 3'd2,
    S_CLR_EDGE = 3'd3,
    S_RD_DATA  = 3'd4,
    S_EMIT     = 3'd5
  } state_t;

  state_t           state_q;
  logic [1:0]       address_q;
  logic             chipselect_q;
  logic             write_n_q;
  logic [31:0]      writedata_q;
  logic             event_valid_q;
  logic [WIDTH-1:0] event_edges_q;
  logic [WIDTH-1:0] event_level_q;
  logic [WIDTH-1:0] edge_q;
  logic [2:0]       cnt_q;
  logic             busy_q;

  logic [WIDTH-1:0] rd_bits;
  logic             unused_readdata;

  assign rd_bits         = readdata[WIDTH-1:0];
  assign unused_readdata = ^readdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_INIT;
      address_q     <= C_ADDR_DATA;
      chipselect_q  <= 1'b0;
      write_n_q     <= 1'b1;
      writedata_q   <= 32'd0;
      event_valid_q <= 1'b0;
      event_edges_q <= '0;
      event_level_q <= '0;
      edge_q        <= '0;
      cnt_q         <= 3'd0;
      busy_q        <= 1'b1;
    end else begin
      case (state_q)
        // First INIT cycle after reset drives the mask write; the second retires it.
        S_INIT: begin
          if (!chipselect_q) begin
            chipselect_q <= 1'b1;
            write_n_q    <= 1'b0;
            address_q    <= C_ADDR_MASK;
            writedata_q  <= 32'(IRQ_MASK);
          end else begin
            chipselect_q <= 1'b0;
            write_n_q    <= 1'b1;
            address_q    <= C_ADDR_DATA;
            writedata_q  <= 32'd0;
            busy_q       <= 1'b0;
            state_q      <= S_IDLE;
          end
        end
        S_IDLE: begin
          if (irq) begin
            chipselect_q <= 1'b1;
            write_n_q    <= 1'b1;
            address_q    <= C_ADDR_EDGE;
            cnt_q        <= 3'd0;
            busy_q       <= 1'b1;
            state_q      <= S_RD_EDGE;
          end
        end
        S_RD_EDGE: begin
          if (cnt_q == C_LAT) begin
            edge_q <= rd_bits;
            if (rd_bits == '0) begin
              chipselect_q <= 1'b0;
              address_q    <= C_ADDR_DATA;
              busy_q       <= 1'b0;
              state_q      <= S_IDLE;
            end else begin
              write_n_q   <= 1'b0;
              writedata_q <= 32'(rd_bits);
              state_q     <= S_CLR_EDGE;
            end
          end else begin
            cnt_q <= cnt_q + 3'd1;
          end
        end
        S_CLR_EDGE: begin
          write_n_q   <= 1'b1;
          writedata_q <= 32'd0;
          address_q   <= C_ADDR_DATA;
          cnt_q       <= 3'd0;
          state_q     <= S_RD_DATA;
        end
        S_RD_DATA: begin
          if (cnt_q == C_LAT) begin
            chipselect_q  <= 1'b0;
            event_valid_q <= 1'b1;
            event_edges_q <= edge_q;
            event_level_q <= rd_bits;
            state_q       <= S_EMIT;
          end else begin
            cnt_q <= cnt_q + 3'd1;
          end
        end
        S_EMIT: begin
          if (event_ready) begin
            event_valid_q <= 1'b0;
            busy_q        <= 1'b0;
            state_q       <= S_IDLE;
          end
        end
        default: begin
          chipselect_q  <= 1'b0;
          write_n_q     <= 1'b1;
          event_valid_q <= 1'b0;
          busy_q        <= 1'b1;
          state_q       <= S_INIT;
        end
      endcase
    end
  end

  assign address     = address_q;
  assign chipselect  = chipselect_q;
  assign write_n     = write_n_q;
  assign writedata   = writedata_q;
  assign event_valid = event_valid_q;
  assign event_edges = event_edges_q;
  assign event_level = event_level_q;
  assign busy        = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_pio_irq_servicer.sv
// tb_pio_irq_servicer: directed bench with a behavioural 2-bit button PIO slave.
// Revision 1.0
`default_nettype none

module tb_pio_irq_servicer;

  logic        clk = 1'b0;
  logic        reset;
  logic        event_ready;
  logic [31:0] readdata = 32'd0;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic        event_valid;
  logic [1:0]  event_edges;
  logic [1:0]  event_level;
  logic        busy;
  wire         irq;

  logic [1:0] in_port   = 2'b00;
  logic [1:0] inj       = 2'b00;
  logic       force_irq = 1'b0;
  logic [1:0] mask_r    = 2'b00;
  logic [1:0] ec_r      = 2'b00;

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0, rd3_cnt = 0, rd0_cnt = 0, xfer_cnt = 0;
  logic [1:0]  last_wa = 2'd0;
  logic [31:0] last_wd = 32'd0;

  pio_irq_servicer #(.WIDTH(2), .IRQ_MASK(2'b11), .READ_LATENCY(1)) dut (
    .clk(clk), .reset(reset), .irq(irq), .readdata(readdata),
    .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .event_valid(event_valid), .event_ready(event_ready),
    .event_edges(event_edges), .event_level(event_level), .busy(busy)
  );

  always #5 clk = ~clk;

  // Slave: registered readdata, clear-on-write edge capture with clear priority.
  assign irq = force_irq | (|(ec_r & mask_r));

  always @(posedge clk) begin
    if (chipselect && write_n) begin
      case (address)
        2'd0:    readdata <= {30'd0, in_port};
        2'd2:    readdata <= {30'd0, mask_r};
        2'd3:    readdata <= {30'd0, ec_r};
        default: readdata <= 32'd0;
      endcase
    end
    if (chipselect && !write_n && address == 2'd2) mask_r <= writedata[1:0];
    if (chipselect && !write_n && address == 2'd3)
      ec_r <= (ec_r | inj) & ~writedata[1:0];
    else
      ec_r <= ec_r | inj;
  end

  always @(posedge clk) begin
    if (chipselect && !write_n) begin
      wr_cnt  <= wr_cnt + 1;
      last_wa <= address;
      last_wd <= writedata;
    end
    if (chipselect && write_n && address == 2'd3) rd3_cnt <= rd3_cnt + 1;
    if (chipselect && write_n && address == 2'd0) rd0_cnt <= rd0_cnt + 1;
    if (event_valid && event_ready) xfer_cnt <= xfer_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input string tag, output int lat);
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (event_valid) begin
        lat = i;
        break;
      end
    end
    check({tag, "_seen"}, {31'd0, event_valid}, 32'd1);
  endtask

  initial begin
    int lat, w0, r30, r00, x0;
    reset = 1'b1; event_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_addr", {30'd0, address}, 32'd0);
    check("rst_cs", {31'd0, chipselect}, 32'd0);
    check("rst_wn", {31'd0, write_n}, 32'd1);
    check("rst_wd", writedata, 32'd0);
    check("rst_valid", {31'd0, event_valid}, 32'd0);
    check("rst_edges", {30'd0, event_edges}, 32'd0);
    check("rst_level", {30'd0, event_level}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd1);

    // Reset release: single mask write, then idle
    w0 = wr_cnt;
    reset = 1'b0;
    @(negedge clk);
    check("init_cs", {31'd0, chipselect}, 32'd1);
    check("init_wn", {31'd0, write_n}, 32'd0);
    check("init_addr", {30'd0, address}, 32'd2);
    check("init_wd", writedata, 32'd3);
    @(negedge clk);
    check("idle_cs", {31'd0, chipselect}, 32'd0);
    check("idle_busy", {31'd0, busy}, 32'd0);
    check("slave_mask", {30'd0, mask_r}, 32'd3);
    check("init_wr_count", wr_cnt - w0, 32'd1);

    // Single press on bit0
    w0 = wr_cnt; r30 = rd3_cnt; r00 = rd0_cnt; x0 = xfer_cnt;
    in_port = 2'b01; inj = 2'b01;
    @(negedge clk); inj = 2'b00;
    check("p0_irq", {31'd0, irq}, 32'd1);
    wait_valid("p0", lat);
    check("p0_latency", lat, 32'd6);
    check("p0_edges", {30'd0, event_edges}, 32'd1);
    check("p0_level", {30'd0, event_level}, 32'd1);
    check("p0_wr_count", wr_cnt - w0, 32'd1);
    check("p0_wr_addr", {30'd0, last_wa}, 32'd3);
    check("p0_wr_data", last_wd, 32'd1);
    check("p0_rd3_cycles", rd3_cnt - r30, 32'd2);
    check("p0_rd0_cycles", rd0_cnt - r00, 32'd2);
    @(negedge clk);
    check("p0_valid_drop", {31'd0, event_valid}, 32'd0);
    check("p0_irq_low", {31'd0, irq}, 32'd0);
    check("p0_xfer", xfer_cnt - x0, 32'd1);

    // Both bits with backpressure
    event_ready = 1'b0; in_port = 2'b11; inj = 2'b11;
    @(negedge clk); inj = 2'b00;
    wait_valid("bp", lat);
    check("bp_level", {30'd0, event_level}, 32'd3);
    w0 = wr_cnt + rd3_cnt + rd0_cnt; x0 = xfer_cnt;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_valid_hold", {31'd0, event_valid}, 32'd1);
      check("bp_edges_hold", {30'd0, event_edges}, 32'd3);
    end
    check("bp_no_bus", (wr_cnt + rd3_cnt + rd0_cnt) - w0, 32'd0);
    check("bp_no_xfer", xfer_cnt - x0, 32'd0);
    event_ready = 1'b1;
    @(negedge clk);
    check("bp_valid_drop", {31'd0, event_valid}, 32'd0);
    check("bp_xfer", xfer_cnt - x0, 32'd1);
    repeat (8) @(negedge clk);
    check("bp_no_dup", xfer_cnt - x0, 32'd1);

    // Spurious irq with empty edge capture
    w0 = wr_cnt; r30 = rd3_cnt; x0 = xfer_cnt;
    force_irq = 1'b1;
    @(negedge clk);
    check("sp_cs", {31'd0, chipselect}, 32'd1);
    check("sp_addr", {30'd0, address}, 32'd3);
    @(negedge clk);
    @(negedge clk);
    check("sp_back_idle", {31'd0, busy}, 32'd0);
    check("sp_idle_cs", {31'd0, chipselect}, 32'd0);
    @(negedge clk);
    check("sp_reread", {31'd0, chipselect}, 32'd1);
    force_irq = 1'b0;
    repeat (4) @(negedge clk);
    check("sp_no_write", wr_cnt - w0, 32'd0);
    check("sp_no_event", xfer_cnt - x0, 32'd0);
    check("sp_rd3_cycles", rd3_cnt - r30, 32'd4);
    check("sp_valid", {31'd0, event_valid}, 32'd0);

    // Second edge arrives while the first event is held
    w0 = wr_cnt; x0 = xfer_cnt;
    event_ready = 1'b0; in_port = 2'b01; inj = 2'b01;
    @(negedge clk); inj = 2'b00;
    wait_valid("e1", lat);
    check("e1_edges", {30'd0, event_edges}, 32'd1);
    check("e1_level", {30'd0, event_level}, 32'd1);
    in_port = 2'b11; inj = 2'b10;
    @(negedge clk); inj = 2'b00;
    @(negedge clk);
    event_ready = 1'b1;
    @(negedge clk);
    wait_valid("e2", lat);
    check("e2_edges", {30'd0, event_edges}, 32'd2);
    check("e2_level", {30'd0, event_level}, 32'd3);
    repeat (10) @(negedge clk);
    check("e12_xfer", xfer_cnt - x0, 32'd2);
    check("e12_clears", wr_cnt - w0, 32'd2);
    check("e12_valid", {31'd0, event_valid}, 32'd0);

    // Reset in the middle of the level read, with a new edge pending in the slave
    in_port = 2'b01; inj = 2'b01;
    @(negedge clk); inj = 2'b00;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (chipselect && write_n && address == 2'd0) break;
    end
    check("mr_in_rd_data", {31'd0, (chipselect && write_n && address == 2'd0)}, 32'd1);
    x0 = xfer_cnt;
    in_port = 2'b10; inj = 2'b10; reset = 1'b1;
    @(negedge clk); inj = 2'b00;
    check("mr_cs", {31'd0, chipselect}, 32'd0);
    check("mr_valid", {31'd0, event_valid}, 32'd0);
    check("mr_busy", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    @(negedge clk);
    check("mr_init_wr", {30'd0, address, chipselect, write_n}, 32'b1010);
    wait_valid("mr", lat);
    check("mr_edges", {30'd0, event_edges}, 32'd2);
    check("mr_level", {30'd0, event_level}, 32'd2);
    @(negedge clk);
    check("mr_xfer", xfer_cnt - x0, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
